// File: rtl/common_pseudo_lru_pkg.sv
// Shared sizing helpers for the tree pseudo-LRU block: way/set widths and tree node count.
// The optional invalid-first victim select is enabled with COMMON_PSEUDO_LRU_INVALID_FIRST_EN.
package common_pseudo_lru_pkg;

    localparam int MAX_SUBJECT_COUNT_LOG2 = 4;
    localparam int MAX_SET_COUNT_LOG2     = 6;

    function automatic int way_count(input int subject_count_log2);
        return 1 << subject_count_log2;
    endfunction

    function automatic int node_count(input int subject_count_log2);
        return (1 << subject_count_log2) - 1;
    endfunction

    // A single-set build still carries a one-bit set index on its ports.
    function automatic int set_width(input int set_count_log2);
        return (set_count_log2 > 0) ? set_count_log2 : 1;
    endfunction

endpackage

// File: rtl/common_pseudo_lru_tree_victim.sv
// Combinational victim walk over one PLRU tree, with optional invalid-first select
// (COMMON_PSEUDO_LRU_INVALID_FIRST_EN adds the per-way valid mask).
module common_pseudo_lru_tree_victim
    import common_pseudo_lru_pkg::*;
#(
    parameter int SUBJECT_COUNT_LOG2 = 2
) (
    input  logic [node_count(SUBJECT_COUNT_LOG2)-1:0] tree,
`ifdef COMMON_PSEUDO_LRU_INVALID_FIRST_EN
    input  logic [way_count(SUBJECT_COUNT_LOG2)-1:0]  mask,
`endif
    output logic [SUBJECT_COUNT_LOG2-1:0]             victim
);

    localparam int WAYS = way_count(SUBJECT_COUNT_LOG2);

    logic [SUBJECT_COUNT_LOG2-1:0] node;
    logic [SUBJECT_COUNT_LOG2-1:0] tree_way;
    logic                          dir;

    // Each node bit selects the child to descend into; the chosen directions spell the way.
    always_comb begin
        node     = '0;
        tree_way = '0;
        dir      = 1'b0;
        for (int d = 0; d < SUBJECT_COUNT_LOG2; d++) begin
            dir                            = tree[node];
            tree_way[SUBJECT_COUNT_LOG2-1-d] = dir;
            node = SUBJECT_COUNT_LOG2'({node, dir}) + SUBJECT_COUNT_LOG2'(1);
        end
    end

`ifdef COMMON_PSEUDO_LRU_INVALID_FIRST_EN
    // Scan downwards so the lowest-index invalid way wins.
    always_comb begin
        victim = tree_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!mask[w]) begin
                victim = SUBJECT_COUNT_LOG2'(w);
            end
        end
    end
`else
    always_comb begin
        victim = tree_way;
    end
`endif

endmodule

// File: rtl/common_pseudo_lru_tree_binr.sv
// Multi-set binary-tree pseudo-LRU with registered victim query and same-cycle touch forwarding.
// Defining COMMON_PSEUDO_LRU_INVALID_FIRST_EN adds qmask and prefers invalid ways as victims.
module common_pseudo_lru_tree_binr
    import common_pseudo_lru_pkg::*;
#(
    parameter int SUBJECT_COUNT_LOG2 = 2,
    parameter int SET_COUNT_LOG2     = 2
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     wen,
    input  logic [set_width(SET_COUNT_LOG2)-1:0]     wset,
    input  logic [SUBJECT_COUNT_LOG2-1:0]            waddr,
    input  logic                                     flush,
    input  logic                                     qen,
    input  logic [set_width(SET_COUNT_LOG2)-1:0]     qset,
`ifdef COMMON_PSEUDO_LRU_INVALID_FIRST_EN
    input  logic [way_count(SUBJECT_COUNT_LOG2)-1:0] qmask,
`endif
    output logic                                     qvalid,
    output logic [SUBJECT_COUNT_LOG2-1:0]            qaddr
);

    localparam int NODES = node_count(SUBJECT_COUNT_LOG2);
    localparam int SETS  = 1 << SET_COUNT_LOG2;
    localparam int SW    = set_width(SET_COUNT_LOG2);

    typedef logic [NODES-1:0] tree_t;

    tree_t                         tree_q [SETS];
    tree_t                         tree_d [SETS];
    tree_t                         q_tree;
    logic [SW-1:0]                 wset_i;
    logic [SW-1:0]                 qset_i;
    logic [SUBJECT_COUNT_LOG2-1:0] victim;
    logic                          qvalid_q, qvalid_d;
    logic [SUBJECT_COUNT_LOG2-1:0] qaddr_q,  qaddr_d;

    // Every node on the path to the touched way is pointed at the sibling subtree.
    function automatic tree_t touch(input tree_t t, input logic [SUBJECT_COUNT_LOG2-1:0] way);
        tree_t                         r;
        logic [SUBJECT_COUNT_LOG2-1:0] node;
        logic                          dir;
        r    = t;
        node = '0;
        for (int d = 0; d < SUBJECT_COUNT_LOG2; d++) begin
            dir     = way[SUBJECT_COUNT_LOG2-1-d];
            r[node] = ~dir;
            node    = SUBJECT_COUNT_LOG2'({node, dir}) + SUBJECT_COUNT_LOG2'(1);
        end
        return r;
    endfunction

    assign wset_i = (SET_COUNT_LOG2 == 0) ? '0 : wset;
    assign qset_i = (SET_COUNT_LOG2 == 0) ? '0 : qset;

    always_comb begin
        tree_d = tree_q;
        if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                tree_d[s] = '0;
            end
        end else if (wen) begin
            tree_d[wset_i] = touch(tree_q[wset_i], waddr);
        end
    end

    // Querying the next-state tree gives flush and same-set touch forwarding for free.
    assign q_tree = tree_d[qset_i];

    common_pseudo_lru_tree_victim #(
        .SUBJECT_COUNT_LOG2 (SUBJECT_COUNT_LOG2)
    ) u_victim (
        .tree   (q_tree),
`ifdef COMMON_PSEUDO_LRU_INVALID_FIRST_EN
        .mask   (qmask),
`endif
        .victim (victim)
    );

    always_comb begin
        qvalid_d = qen;
        qaddr_d  = qen ? victim : qaddr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                tree_q[s] <= '0;
            end
            qvalid_q <= 1'b0;
            qaddr_q  <= '0;
        end else begin
            tree_q   <= tree_d;
            qvalid_q <= qvalid_d;
            qaddr_q  <= qaddr_d;
        end
    end

    assign qvalid = qvalid_q;
    assign qaddr  = qaddr_q;

endmodule

// File: tb/tb_common_pseudo_lru_tree_binr.sv
// Bench for common_pseudo_lru_tree_binr: directed scenarios plus random traffic against a
// per-set node-bit model; COMMON_PSEUDO_LRU_INVALID_FIRST_EN also exercises qmask.
module tb_common_pseudo_lru_tree_binr;

    localparam int L     = 2;
    localparam int WAYS  = 4;
    localparam int NODES = 3;
    localparam int SETS  = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       wen   = 1'b0;
    logic [1:0] wset  = '0;
    logic [1:0] waddr = '0;
    logic       flush = 1'b0;
    logic       qen   = 1'b0;
    logic [1:0] qset  = '0;
`ifdef COMMON_PSEUDO_LRU_INVALID_FIRST_EN
    logic [3:0] qmask = 4'b1111;
`endif
    logic       qvalid;
    logic [1:0] qaddr;

    int n_cmp = 0;
    int n_bad = 0;
    bit mtree [SETS][NODES];
    int exp_qvalid = 0;
    int exp_qaddr  = 0;

    common_pseudo_lru_tree_binr #(
        .SUBJECT_COUNT_LOG2 (2),
        .SET_COUNT_LOG2     (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .wen    (wen),
        .wset   (wset),
        .waddr  (waddr),
        .flush  (flush),
        .qen    (qen),
        .qset   (qset),
`ifdef COMMON_PSEUDO_LRU_INVALID_FIRST_EN
        .qmask  (qmask),
`endif
        .qvalid (qvalid),
        .qaddr  (qaddr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++)
            for (int n = 0; n < NODES; n++)
                mtree[s][n] = 1'b0;
    endfunction

    // Level d holds nodes (2^d - 1) .. (2^(d+1) - 2); the way's top d bits pick one of them.
    function automatic void model_touch(input int s, input int w);
        for (int d = 0; d < L; d++) begin
            int node;
            node = (1 << d) - 1 + (w >> (L - d));
            mtree[s][node] = (((w >> (L - 1 - d)) & 1) == 0);
        end
    endfunction

    function automatic int model_victim(input int s);
        int v;
        v = 0;
        for (int d = 0; d < L; d++)
            v = 2 * v + int'(mtree[s][(1 << d) - 1 + v]);
`ifdef COMMON_PSEUDO_LRU_INVALID_FIRST_EN
        for (int w = WAYS - 1; w >= 0; w--)
            if (!qmask[w]) v = w;
`endif
        return v;
    endfunction

    task automatic set_in(input bit w, input int ws, input int wa, input bit f,
                          input bit q, input int qs);
        wen   = w;
        wset  = 2'(ws);
        waddr = 2'(wa);
        flush = f;
        qen   = q;
        qset  = 2'(qs);
    endtask

    // One clock: the model applies the cycle's flush/touch, then answers the query.
    task automatic cycle(input string tag);
        @(posedge clk);
        #1;
        if (flush) model_clear();
        else if (wen) model_touch(int'(wset), int'(waddr));
        if (qen) begin
            exp_qvalid = 1;
            exp_qaddr  = model_victim(int'(qset));
        end else begin
            exp_qvalid = 0;
        end
        check({tag, "_qvalid"}, 32'(qvalid), 32'(exp_qvalid));
        check({tag, "_qaddr"},  32'(qaddr),  32'(exp_qaddr));
    endtask

    task automatic query(input int s, input string tag, input int lit);
        set_in(0, 0, 0, 0, 1, s);
        cycle(tag);
        check({tag, "_lit"}, 32'(qaddr), 32'(lit));
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("in_reset_qvalid", 32'(qvalid), 0);
        check("in_reset_qaddr",  32'(qaddr),  0);
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        cycle("idle");

        query(0, "post_reset_q", 0);

        set_in(1, 1, 0, 0, 0, 0); cycle("t0");
        query(1, "seq_a", 2);
        set_in(1, 1, 2, 0, 0, 0); cycle("t2");
        query(1, "seq_b", 1);
        set_in(1, 1, 1, 0, 0, 0); cycle("t1");
        query(1, "seq_c", 3);
        set_in(1, 1, 3, 0, 0, 0); cycle("t3");
        query(1, "seq_d", 0);
        query(0, "set0_untouched", 0);

        set_in(1, 2, 0, 0, 1, 2); cycle("fwd");
        check("fwd_lit", 32'(qaddr), 2);

        set_in(1, 1, 0, 1, 0, 0); cycle("flush_wen");
        query(1, "flush_q", 0);
        query(2, "flush_q2", 0);

        set_in(1, 3, 1, 1, 1, 3); cycle("flush_fwd");
        check("flush_fwd_lit", 32'(qaddr), 0);

        set_in(0, 0, 0, 0, 0, 0); cycle("hold");
        check("hold_lit", 32'(qaddr), 0);

`ifdef COMMON_PSEUDO_LRU_INVALID_FIRST_EN
        qmask = 4'b1011; query(0, "mask_1011", 2);
        qmask = 4'b1111; query(0, "mask_1111", 0);
`endif

        for (int i = 0; i < 400; i++) begin
            set_in(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), ($urandom_range(0, 31) == 0),
                   bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
`ifdef COMMON_PSEUDO_LRU_INVALID_FIRST_EN
            qmask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
`endif
            cycle("rand");
        end
`ifdef COMMON_PSEUDO_LRU_INVALID_FIRST_EN
        qmask = 4'b1111;
`endif

        set_in(1, 1, 2, 0, 0, 0); cycle("pre_rst_touch");
        set_in(0, 0, 0, 0, 1, 1); cycle("pre_rst_q");
        set_in(1, 1, 0, 0, 1, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_qvalid", 32'(qvalid), 0);
        check("async_rst_qaddr",  32'(qaddr),  0);
        @(posedge clk);
        #1;
        check("rst_held_qvalid", 32'(qvalid), 0);
        reset = 1'b0;
        model_clear();
        exp_qaddr = 0;
        set_in(0, 0, 0, 0, 0, 0);
        cycle("post_rst_idle");
        query(1, "post_rst_set1", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/common_pseudo_lru_tree_binr.md
COMMON_PSEUDO_LRU_TREE_BINR -- requirements
Module: common_pseudo_lru_tree_binr

Interface
REQ-001 SHALL have parameter SUBJECT_COUNT_LOG2, default 2, meaning log2 of ways per set (range 1..4).
REQ-002 SHALL have parameter SET_COUNT_LOG2, default 2, meaning log2 of independent LRU sets (range 0..6; 0 = single set).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wen  input  1  touch strobe: mark way as most-recently-used.
REQ-006 SHALL have port wset  input  max(SET_COUNT_LOG2,1)  touch set index, binary.
REQ-007 SHALL have port waddr  input  SUBJECT_COUNT_LOG2  touched way, binary.
REQ-008 SHALL have port flush  input  1  synchronous clear of all sets.
REQ-009 SHALL have port qen  input  1  victim query strobe.
REQ-010 SHALL have port qset  input  max(SET_COUNT_LOG2,1)  query set index.
REQ-011 SHALL have port qvalid  output  1  query result valid, registered.
REQ-012 SHALL have port qaddr  output  SUBJECT_COUNT_LOG2  victim way, binary, registered.
REQ-013 SHALL have, only with the macro of REQ-029, port qmask  input  1<<SUBJECT_COUNT_LOG2  per-way valid bits for the queried set.

Function
REQ-014 SHALL hold per set a tree of (1<<SUBJECT_COUNT_LOG2)-1 bits; node i children 2i+1 (left), 2i+2 (right); bit 0 = victim in left subtree.
REQ-015 SHALL on wen, for each node on the root-to-leaf path of waddr, set the bit to point away from waddr (left child on path -> 1, right -> 0); off-path bits are unchanged.
REQ-016 SHALL derive victim by walking from root following node bits; the resulting leaf index is the victim way.
REQ-017 SHALL register the query: qen at cycle N -> qvalid=1 and qaddr valid at cycle N+1; qen=0 -> qvalid=0 next cycle; qaddr holds last value.
REQ-018 SHALL forward a same-cycle touch: if wen and qen both asserted with wset==qset, the victim is computed from the post-touch tree.
REQ-019 SHALL touch only set wset; other sets unchanged.
REQ-020 SHALL on flush clear every tree bit at the next edge; flush has priority over a same-cycle wen (touch discarded).
REQ-021 SHALL answer a query coincident with flush from the post-flush (all-zero) tree, i.e. qaddr=0 without mask.
REQ-022 SHALL ignore upper index bits when SET_COUNT_LOG2=0 (single set).
REQ-023 SHALL be a pure function of state for back-to-back touches: one touch per cycle, no stalls, no busy output.

Reset
REQ-024 SHALL clear all tree bits asynchronously on reset=1.
REQ-025 SHALL drive qvalid=0 and qaddr=0 during and after reset until the first qen.
REQ-026 SHALL discard any touch, flush or query in a cycle where reset is asserted; a reset mid-stream leaves no pending result.

Configuration
REQ-027 SHALL compile without COMMON_PSEUDO_LRU_INVALID_FIRST_EN as pure tree PLRU; qmask absent.
REQ-028 SHALL, with COMMON_PSEUDO_LRU_INVALID_FIRST_EN defined, add qmask.
REQ-029 SHALL, with the macro, return the lowest-index way with qmask bit 0 if any; else tree victim per REQ-016; qmask never alters tree state.

Structure
REQ-030 SHALL place way/set width constants and tree node-count function in shared package common_pseudo_lru_pkg.
REQ-031 SHALL implement victim walk (and optional invalid-first select) in sub-module common_pseudo_lru_tree_victim, combinational, one instance on the query path.
REQ-032 SHALL store trees in flip-flops, not RAM, so a query after a touch sees it without extra latency.

Verification (SUBJECT_COUNT_LOG2=2, SET_COUNT_LOG2=2)
REQ-033 SHALL test reset: assert reset, release, qen qset=0 -> next cycle qvalid=1 qaddr=0.
REQ-034 SHALL test sequence on set 1: touch 0 -> query 2; touch 2 -> query 1; touch 1 -> query 3; touch 3 -> query 0; set 0 query still 0.
REQ-035 SHALL test forwarding: set 2 fresh, same cycle wen waddr=0 wset=2 and qen qset=2 -> qaddr=2 next cycle.
REQ-036 SHALL test flush: after REQ-034, flush with concurrent wen waddr=0 wset=1 -> query set 1 returns 0.
REQ-037 SHALL test macro build: tree victim 0, qmask=4'b1011 -> qaddr=2; qmask=4'b1111 -> qaddr=0.
REQ-038 SHALL test async reset mid-stream: reset asserted between edges during qen -> qvalid=0 immediately, no result after release.
